// File: rtl/button_tick_array_pkg.sv
// button_tick_array_pkg
//   Shared definitions for the button front end: per-channel FSM state
//   encoding and the counter-width helper used by every channel.
package button_tick_array_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_e;

  // Counter wide enough for the largest cycle parameter, plus one bit of
  // headroom so the repeat compare values fit without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_tick_array_channel.sv
// button_tick_array_channel
//   One button channel: SYNC_STAGES-deep synchroniser, debounce FSM with a
//   shared cycle counter, and registered press / release / level outputs.
// Ports
//   i_CLK       system clock, rising edge
//   i_RST       synchronous active-high reset
//   i_BTN       raw asynchronous button level (1 = pressed)
//   o_TICK      1-cycle pulse on accepted press or auto-repeat
//   o_REL_TICK  1-cycle pulse on accepted release
//   o_LEVEL     debounced level
module button_tick_array_channel
  import button_tick_array_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_BTN,
  output logic o_TICK,
  output logic o_REL_TICK,
  output logic o_LEVEL
);

  localparam int CW = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  // Repeat compares against the full delay/period (not -1): the cycle spent
  // reloading the counter is part of the required repeat interval.
  localparam logic [CW-1:0] RPT_DLY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RPT_PER  = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  btn_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_rpt, w_rpt_nxt;
  logic          r_tick, w_tick_nxt;
  logic          r_rel, w_rel_nxt;
  logic          r_level, w_level_nxt;
  logic [CW-1:0] w_rpt_tgt;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rpt_tgt = r_rpt ? RPT_PER : RPT_DLY;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_sync  <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rpt   <= 1'b0;
      r_tick  <= 1'b0;
      r_rel   <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_BTN};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rpt   <= w_rpt_nxt;
      r_tick  <= w_tick_nxt;
      r_rel   <= w_rel_nxt;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rpt_nxt   = r_rpt;
    w_tick_nxt  = 1'b0;
    w_rel_nxt   = 1'b0;
    w_level_nxt = r_level;
    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = DB_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      DB_PRESS: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_rpt_nxt   = 1'b0;
          w_tick_nxt  = 1'b1;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nxt = DB_RELEASE;
          w_cnt_nxt   = '0;
        end else if ((REPEAT_EN != 0) && (r_cnt == w_rpt_tgt)) begin
          w_tick_nxt = 1'b1;
          w_cnt_nxt  = '0;
          w_rpt_nxt  = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          // Saturate so a long hold without repeat never wraps.
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DB_RELEASE: begin
        if (w_s) begin
          // Release bounce: back to held, repeat phase flag untouched.
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_rel_nxt   = 1'b1;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_TICK     = r_tick;
  assign o_REL_TICK = r_rel;
  assign o_LEVEL    = r_level;

endmodule

// File: rtl/button_tick_array.sv
// button_tick_array
//   N_CH-channel button front end. Each channel is an independent
//   synchronise / debounce / tick unit; outputs are simply concatenated.
// Ports
//   i_CLK       system clock, rising edge
//   i_RST       synchronous active-high reset
//   i_BTN       [N_CH] raw asynchronous button levels (1 = pressed)
//   o_TICK      [N_CH] 1-cycle press or auto-repeat pulses
//   o_REL_TICK  [N_CH] 1-cycle release pulses
//   o_LEVEL     [N_CH] debounced levels
module button_tick_array #(
  parameter int N_CH          = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic [N_CH-1:0] i_BTN,
  output logic [N_CH-1:0] o_TICK,
  output logic [N_CH-1:0] o_REL_TICK,
  output logic [N_CH-1:0] o_LEVEL
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_tick_array_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .i_CLK     (i_CLK),
      .i_RST     (i_RST),
      .i_BTN     (i_BTN[g]),
      .o_TICK    (o_TICK[g]),
      .o_REL_TICK(o_REL_TICK[g]),
      .o_LEVEL   (o_LEVEL[g])
    );
  end

endmodule

// File: tb/tb_button_tick_array.sv
// tb_button_tick_array
//   Directed vector bench: main DUT with auto-repeat, second DUT without
//   repeat for the reset-while-held sequence.
module tb_button_tick_array;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst, rst_b;
  logic [N-1:0] btn, btn_b;
  logic [N-1:0] tick, rel, lvl;
  logic [N-1:0] tick_b, rel_b, lvl_b;

  always #5 clk = ~clk;

  button_tick_array #(
    .N_CH(N), .SYNC_STAGES(2), .DB_CYCLES(4),
    .REPEAT_EN(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_BTN(btn),
    .o_TICK(tick), .o_REL_TICK(rel), .o_LEVEL(lvl)
  );

  button_tick_array #(
    .N_CH(N), .SYNC_STAGES(2), .DB_CYCLES(4),
    .REPEAT_EN(0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut0 (
    .i_CLK(clk), .i_RST(rst_b), .i_BTN(btn_b),
    .o_TICK(tick_b), .o_REL_TICK(rel_b), .o_LEVEL(lvl_b)
  );

  typedef struct {
    logic [N-1:0] btn;
    logic [N-1:0] tick;
    logic [N-1:0] rel;
    logic [N-1:0] lvl;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push(input int n, input logic [N-1:0] b, input logic [N-1:0] t,
                      input logic [N-1:0] r, input logic [N-1:0] l);
    for (int i = 0; i < n; i++) vq.push_back('{btn: b, tick: t, rel: r, lvl: l});
  endtask

  task automatic chk(input string nm, input int idx, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %b, expected %b", nm, idx, act, exp);
    end
  endtask

  // One cycle on the no-repeat DUT: drive at negedge, check just after posedge.
  task automatic step_b(input string nm, input int idx, input logic r, input logic [N-1:0] b,
                        input logic [N-1:0] t, input logic [N-1:0] rl, input logic [N-1:0] l);
    @(negedge clk);
    rst_b = r;
    btn_b = b;
    @(posedge clk);
    #1;
    n_vec++;
    chk({nm, ".tick"}, idx, tick_b, t);
    chk({nm, ".rel"},  idx, rel_b,  rl);
    chk({nm, ".lvl"},  idx, lvl_b,  l);
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1; btn = '0; btn_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    chk("rst.tick", 0, tick, '0);
    chk("rst.rel",  0, rel,  '0);
    chk("rst.lvl",  0, lvl,  '0);
    @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;

    // Clean ch0 press held 40 cycles: tick at +6, repeats at +15 then every 4.
    push(6, 3'b001, 3'b000, 3'b000, 3'b000);
    push(1, 3'b001, 3'b001, 3'b000, 3'b001);
    push(8, 3'b001, 3'b000, 3'b000, 3'b001);
    push(1, 3'b001, 3'b001, 3'b000, 3'b001);
    for (int j = 0; j < 6; j++) begin
      push(3, 3'b001, 3'b000, 3'b000, 3'b001);
      push(1, 3'b001, 3'b001, 3'b000, 3'b001);
    end
    push(6, 3'b000, 3'b000, 3'b000, 3'b001);
    push(1, 3'b000, 3'b000, 3'b001, 3'b000);
    push(4, 3'b000, 3'b000, 3'b000, 3'b000);

    // Bouncy ch1 press 1,0,1,0 then steady: tick 6 edges after last rise.
    push(1, 3'b010, 3'b000, 3'b000, 3'b000);
    push(1, 3'b000, 3'b000, 3'b000, 3'b000);
    push(1, 3'b010, 3'b000, 3'b000, 3'b000);
    push(1, 3'b000, 3'b000, 3'b000, 3'b000);
    push(6, 3'b010, 3'b000, 3'b000, 3'b000);
    push(1, 3'b010, 3'b010, 3'b000, 3'b010);
    push(3, 3'b010, 3'b000, 3'b000, 3'b010);
    push(6, 3'b000, 3'b000, 3'b000, 3'b010);
    push(1, 3'b000, 3'b000, 3'b010, 3'b000);
    push(4, 3'b000, 3'b000, 3'b000, 3'b000);

    // 3-cycle glitch on ch2: nothing at all.
    push(3, 3'b100, 3'b000, 3'b000, 3'b000);
    push(8, 3'b000, 3'b000, 3'b000, 3'b000);

    // ch0 release with a 2-cycle bounce back high, then clean release.
    push(6, 3'b001, 3'b000, 3'b000, 3'b000);
    push(1, 3'b001, 3'b001, 3'b000, 3'b001);
    push(1, 3'b001, 3'b000, 3'b000, 3'b001);
    push(2, 3'b000, 3'b000, 3'b000, 3'b001);
    push(2, 3'b001, 3'b000, 3'b000, 3'b001);
    push(6, 3'b000, 3'b000, 3'b000, 3'b001);
    push(1, 3'b000, 3'b000, 3'b001, 3'b000);
    push(3, 3'b000, 3'b000, 3'b000, 3'b000);

    // All channels on the same edge.
    push(6, 3'b111, 3'b000, 3'b000, 3'b000);
    push(1, 3'b111, 3'b111, 3'b000, 3'b111);
    push(1, 3'b111, 3'b000, 3'b000, 3'b111);
    push(6, 3'b000, 3'b000, 3'b000, 3'b111);
    push(1, 3'b000, 3'b000, 3'b111, 3'b000);
    push(3, 3'b000, 3'b000, 3'b000, 3'b000);

    foreach (vq[i]) begin
      @(negedge clk);
      btn = vq[i].btn;
      @(posedge clk);
      #1;
      n_vec++;
      chk("tick", i, tick, vq[i].tick);
      chk("rel",  i, rel,  vq[i].rel);
      chk("lvl",  i, lvl,  vq[i].lvl);
    end

    // No-repeat DUT: press ch0, hold (no repeats), reset while held,
    // then a fresh press tick 6 edges after reset deasserts, never a release.
    for (int i = 0; i < 6; i++) step_b("nr.press", i, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
    step_b("nr.press", 6, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
    for (int i = 7; i < 19; i++) step_b("nr.hold", i, 1'b0, 3'b001, 3'b000, 3'b000, 3'b001);
    step_b("nr.rst", 0, 1'b1, 3'b001, 3'b000, 3'b000, 3'b000);
    for (int i = 1; i < 7; i++) step_b("nr.redb", i, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
    step_b("nr.retick", 7, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
    for (int i = 8; i < 11; i++) step_b("nr.rehold", i, 1'b0, 3'b001, 3'b000, 3'b000, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
